glitch_pulse_gen: RTL and testbench
===================================

GLITCH_PULSE_GEN -- requirements
Module: glitch_pulse_gen

Interface
REQ-001 SHALL have parameter DELAY_W, default 16, meaning width of delay port and delay counter.
REQ-002 SHALL have parameter WIDTH_W, default 8, meaning width of width and gap ports and their counter.
REQ-003 SHALL have parameter COUNT_W, default 4, meaning width of count port and pulse counter.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port arm  input  1  level; high enables one glitch sequence.
REQ-007 SHALL have port trigger  input  1  level from upstream edge detector; high starts the sequence.
REQ-008 SHALL have port delay  input  DELAY_W  cycles from trigger to first pulse.
REQ-009 SHALL have port width  input  WIDTH_W  pulse high time in cycles; 0 treated as 1.
REQ-010 SHALL have port count  input  COUNT_W  number of pulses; 0 treated as 1.
REQ-011 SHALL have port gap  input  WIDTH_W  low time between pulses in cycles; 0 treated as 1.
REQ-012 SHALL have port glitch  output  1  registered glitch drive.
REQ-013 SHALL have port busy  output  1  high in ARMED, DELAY, PULSE, GAP.
REQ-014 SHALL have port done  output  1  high in DONE.

Function
REQ-015 SHALL implement states IDLE, ARMED, DELAY, PULSE, GAP, DONE.
REQ-016 IDLE: arm high -> ARMED; delay, width, count, gap latched on that edge; later port changes ignored until next IDLE.
REQ-017 Trigger SHALL be ignored in IDLE, including the cycle arm is accepted.
REQ-018 ARMED: trigger sampled high at edge N -> DELAY with delay counter loaded from latched delay; if latched delay is 0, go directly to PULSE.
REQ-019 glitch SHALL first be high in the cycle following edge N+1+delay, i.e. delay=0 gives glitch high the cycle after trigger is sampled.
REQ-020 PULSE: glitch high for exactly max(width,1) consecutive cycles.
REQ-021 After each pulse, if pulses emitted < max(count,1) -> GAP, glitch low for exactly max(gap,1) cycles, then PULSE; else -> DONE.
REQ-022 DONE: glitch low; remain until arm low, then IDLE.
REQ-023 arm low in ARMED, DELAY, PULSE or GAP SHALL abort to IDLE; glitch low from the next cycle; done never asserted.
REQ-024 Trigger level changes after ARMED exit SHALL have no effect; retrigger requires a new arm cycle.
REQ-025 Delay counter SHALL not wrap; maximum delay 2^DELAY_W-1 is honoured exactly.
REQ-026 glitch SHALL be driven directly from a flop, no combinational path from any input.

Reset
REQ-027 rst high SHALL force state IDLE, glitch 0, busy 0, done 0, all counters and latched values 0 on the next edge, overriding any other input.
REQ-028 rst asserted mid-pulse SHALL drop glitch after that edge; no sequence resumes after rst release without a new arm rising from IDLE.

Configuration
REQ-029 Macro GLITCH_REPEAT_EN defined: count and gap honoured as in REQ-021; GAP state present.
REQ-030 GLITCH_REPEAT_EN undefined: count and gap ports present but ignored; exactly one pulse per sequence; PULSE -> DONE; GAP state absent.

Verification
REQ-031 arm=1, delay=0, width=1, trigger pulse at edge N -> glitch high one cycle in cycle after N, then done=1 until arm=0.
REQ-032 delay=5, width=3 -> glitch rises 6 cycles after trigger sample, high 3 cycles, busy high throughout, done after.
REQ-033 GLITCH_REPEAT_EN, count=3, width=2, gap=4 -> pattern 2 high, 4 low, 2 high, 4 low, 2 high, then done.
REQ-034 width=0, count=0, gap=0 -> behaves as 1/1/1; arm+trigger both rising in same IDLE cycle -> trigger ignored, waits for next trigger.
REQ-035 arm dropped in DELAY, and separately rst asserted mid-PULSE -> glitch 0 next cycle, IDLE, done stays 0.
REQ-036 GLITCH_REPEAT_EN undefined, count=5 -> single pulse then done; changing delay while busy -> no effect on timing.

Source files
------------

// File: rtl/glitch_pulse_gen.sv
// Armed, trigger-started glitch pulse generator: delay, then width-cycle pulses.
// Define GLITCH_REPEAT_EN to enable multi-pulse trains (count/gap); otherwise one pulse.
module glitch_pulse_gen #(
  parameter int unsigned DELAY_W = 16,
  parameter int unsigned WIDTH_W = 8,
  parameter int unsigned COUNT_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               arm,
  input  logic               trigger,
  input  logic [DELAY_W-1:0] delay,
  input  logic [WIDTH_W-1:0] width,
  input  logic [COUNT_W-1:0] count,
  input  logic [WIDTH_W-1:0] gap,
  output logic               glitch,
  output logic               busy,
  output logic               done
);

  // state | meaning
  // IDLE  | waiting for arm     ARMED | waiting for trigger   DELAY | counting delay
  // PULSE | pulse high phase    GAP   | low between pulses    DONE  | wait for arm low
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARMED = 3'd1,
    S_DELAY = 3'd2,
    S_PULSE = 3'd3,
`ifdef GLITCH_REPEAT_EN
    S_GAP   = 3'd4,
`endif
    S_DONE  = 3'd5
  } state_t;

  localparam logic [DELAY_W-1:0] D_ONE = DELAY_W'(1);
  localparam logic [WIDTH_W-1:0] W_ONE = WIDTH_W'(1);

  state_t               state_q;
  logic [DELAY_W-1:0]   delay_q;
  logic [WIDTH_W-1:0]   width_q;
  logic [DELAY_W-1:0]   dcnt_q;
  logic [WIDTH_W-1:0]   wcnt_q;
  logic                 glitch_q;
  logic                 busy_q;
  logic                 done_q;
  logic [WIDTH_W-1:0]   width_eff;
  logic                 in_busy;

  assign width_eff = (width_q == '0) ? W_ONE : width_q;

`ifdef GLITCH_REPEAT_EN
  localparam logic [COUNT_W-1:0] C_ONE = COUNT_W'(1);

  logic [COUNT_W-1:0]   count_q;
  logic [WIDTH_W-1:0]   gap_q;
  logic [COUNT_W-1:0]   pulses_q;
  logic [COUNT_W-1:0]   count_eff;
  logic [WIDTH_W-1:0]   gap_eff;

  assign count_eff = (count_q == '0) ? C_ONE : count_q;
  assign gap_eff   = (gap_q == '0) ? W_ONE : gap_q;
`else
  logic unused_cfg;
  assign unused_cfg = ^{count, gap};
`endif

  always_comb begin
    in_busy = 1'b0;
    case (state_q)
      S_ARMED, S_DELAY, S_PULSE: in_busy = 1'b1;
`ifdef GLITCH_REPEAT_EN
      S_GAP:                     in_busy = 1'b1;
`endif
      default:                   in_busy = 1'b0;
    endcase
  end

  // Outputs trail the state by one edge, which places the first glitch cycle
  // at delay+1 edges after the trigger sample; arm low kills them immediately.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      delay_q  <= '0;
      width_q  <= '0;
      dcnt_q   <= '0;
      wcnt_q   <= '0;
      glitch_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef GLITCH_REPEAT_EN
      count_q  <= '0;
      gap_q    <= '0;
      pulses_q <= '0;
`endif
    end else begin
      glitch_q <= arm && (state_q == S_PULSE);
      busy_q   <= arm && in_busy;
      done_q   <= arm && (state_q == S_DONE);

      case (state_q)
        S_IDLE: begin
          if (arm) begin
            state_q <= S_ARMED;
            delay_q <= delay;
            width_q <= width;
`ifdef GLITCH_REPEAT_EN
            count_q <= count;
            gap_q   <= gap;
`endif
          end
        end

        S_ARMED: begin
          if (!arm) begin
            state_q <= S_IDLE;
          end else if (trigger) begin
`ifdef GLITCH_REPEAT_EN
            pulses_q <= count_eff;
`endif
            if (delay_q == '0) begin
              state_q <= S_PULSE;
              wcnt_q  <= width_eff;
            end else begin
              state_q <= S_DELAY;
              dcnt_q  <= delay_q;
            end
          end
        end

        S_DELAY: begin
          if (!arm) begin
            state_q <= S_IDLE;
          end else if (dcnt_q == D_ONE) begin
            state_q <= S_PULSE;
            wcnt_q  <= width_eff;
          end else begin
            dcnt_q <= dcnt_q - D_ONE;
          end
        end

        S_PULSE: begin
          if (!arm) begin
            state_q <= S_IDLE;
          end else if (wcnt_q == W_ONE) begin
`ifdef GLITCH_REPEAT_EN
            if (pulses_q == C_ONE) begin
              state_q <= S_DONE;
            end else begin
              state_q  <= S_GAP;
              wcnt_q   <= gap_eff;
              pulses_q <= pulses_q - C_ONE;
            end
`else
            state_q <= S_DONE;
`endif
          end else begin
            wcnt_q <= wcnt_q - W_ONE;
          end
        end

`ifdef GLITCH_REPEAT_EN
        S_GAP: begin
          if (!arm) begin
            state_q <= S_IDLE;
          end else if (wcnt_q == W_ONE) begin
            state_q <= S_PULSE;
            wcnt_q  <= width_eff;
          end else begin
            wcnt_q <= wcnt_q - W_ONE;
          end
        end
`endif

        S_DONE: begin
          if (!arm) state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign glitch = glitch_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_glitch_pulse_gen.sv
// Directed bench for glitch_pulse_gen; outputs sampled 1 time unit after each rising edge.
module tb_glitch_pulse_gen;

  logic        clk;
  logic        rst;
  logic        arm;
  logic        trigger;
  logic [15:0] delay;
  logic [7:0]  width;
  logic [3:0]  count;
  logic [7:0]  gap;
  logic        glitch;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  glitch_pulse_gen #(.DELAY_W(16), .WIDTH_W(8), .COUNT_W(4)) dut (
    .clk(clk), .rst(rst), .arm(arm), .trigger(trigger),
    .delay(delay), .width(width), .count(count), .gap(gap),
    .glitch(glitch), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; arm = 1'b0; trigger = 1'b0;
    delay = 16'd0; width = 8'd1; count = 4'd1; gap = 8'd1;
    step(); step();
    chk("reset_glitch", glitch, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    rst = 1'b0;

    // delay 0, width 1: one glitch cycle right after the trigger sample
    arm = 1'b1;
    step();
    chk("t1_accept_busy", busy, 0);
    step();
    chk("t1_armed_busy", busy, 1);
    chk("t1_armed_glitch", glitch, 0);
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    chk("t1_trig_glitch", glitch, 0);
    step();
    chk("t1_pulse_glitch", glitch, 1);
    chk("t1_pulse_busy", busy, 1);
    step();
    chk("t1_after_glitch", glitch, 0);
    chk("t1_after_done", done, 1);
    chk("t1_after_busy", busy, 0);
    step(); step();
    chk("t1_done_hold", done, 1);
    arm = 1'b0;
    step();
    chk("t1_disarm_done", done, 0);

    // delay 5, width 3; delay port changed while busy must not matter
    delay = 16'd5; width = 8'd3; count = 4'd1;
    arm = 1'b1;
    step(); step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    delay = 16'd1;
    for (int k = 1; k <= 5; k++) begin
      step();
      chk("t2_delay_glitch", glitch, 0);
      chk("t2_delay_busy", busy, 1);
    end
    for (int k = 6; k <= 8; k++) begin
      step();
      chk("t2_pulse_glitch", glitch, 1);
      chk("t2_pulse_busy", busy, 1);
    end
    step();
    chk("t2_end_glitch", glitch, 0);
    chk("t2_end_done", done, 1);
    arm = 1'b0;
    step();

    // zero width/count/gap act as 1; trigger with arm accept is ignored
    delay = 16'd0; width = 8'd0; count = 4'd0; gap = 8'd0;
    arm = 1'b1; trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("t3_wait_glitch", glitch, 0);
      chk("t3_wait_busy", busy, 1);
    end
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    chk("t3_pulse_glitch", glitch, 1);
    step();
    chk("t3_end_glitch", glitch, 0);
    chk("t3_end_done", done, 1);
    arm = 1'b0;
    step();

    // arm dropped during DELAY aborts silently
    delay = 16'd10; width = 8'd2; count = 4'd1;
    arm = 1'b1;
    step(); step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step(); step();
    arm = 1'b0;
    step();
    chk("t4_abort_glitch", glitch, 0);
    chk("t4_abort_busy", busy, 0);
    chk("t4_abort_done", done, 0);
    trigger = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      chk("t4_idle_glitch", glitch, 0);
      chk("t4_idle_done", done, 0);
    end
    trigger = 1'b0;

    // rst mid-pulse drops glitch on that edge; nothing resumes without a trigger
    delay = 16'd0; width = 8'd4;
    arm = 1'b1;
    step(); step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    chk("t5_pulse_glitch", glitch, 1);
    step();
    rst = 1'b1;
    step();
    chk("t5_rst_glitch", glitch, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_done", done, 0);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t5_post_glitch", glitch, 0);
      chk("t5_post_done", done, 0);
    end
    arm = 1'b0;
    step();

`ifdef GLITCH_REPEAT_EN
    // count 3, width 2, gap 4: period of 6 edges, last pulse ends at edge 14
    delay = 16'd0; width = 8'd2; count = 4'd3; gap = 8'd4;
    arm = 1'b1;
    step(); step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      step();
      chk("t6_train_glitch", glitch, (((k - 1) % 6) < 2) ? 1 : 0);
      chk("t6_train_done", done, 0);
    end
    step();
    chk("t6_end_glitch", glitch, 0);
    chk("t6_end_done", done, 1);
`else
    // count and gap ignored: exactly one width-2 pulse
    delay = 16'd0; width = 8'd2; count = 4'd5; gap = 8'd3;
    arm = 1'b1;
    step(); step();
    trigger = 1'b1;
    step();
    trigger = 1'b0;
    step();
    chk("t6_single_glitch1", glitch, 1);
    step();
    chk("t6_single_glitch2", glitch, 1);
    step();
    chk("t6_single_end", glitch, 0);
    chk("t6_single_done", done, 1);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t6_single_quiet", glitch, 0);
    end
`endif
    arm = 1'b0;
    step();
    chk("final_done", done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
